// File: rtl/apb2axil_if.sv
// Bus bundle for the APB4-to-AXI4-Lite bridge: APB completer side plus AXI-Lite manager side.
// The bridge takes the slave modport; the requester/memory environment takes the master modport.
interface apb2axil_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic            psel;
  logic            penable;
  logic            pwrite;
  logic [AW-1:0]   paddr;
  logic [2:0]      pprot;
  logic [DW-1:0]   pwdata;
  logic [DW/8-1:0] pstrb;
  logic            pready;
  logic [DW-1:0]   prdata;
  logic            pslverr;

  logic [AW-1:0]   m_axi_awaddr;
  logic [2:0]      m_axi_awprot;
  logic            m_axi_awvalid;
  logic            m_axi_awready;
  logic [DW-1:0]   m_axi_wdata;
  logic [DW/8-1:0] m_axi_wstrb;
  logic            m_axi_wvalid;
  logic            m_axi_wready;
  logic [1:0]      m_axi_bresp;
  logic            m_axi_bvalid;
  logic            m_axi_bready;
  logic [AW-1:0]   m_axi_araddr;
  logic [2:0]      m_axi_arprot;
  logic            m_axi_arvalid;
  logic            m_axi_arready;
  logic [DW-1:0]   m_axi_rdata;
  logic [1:0]      m_axi_rresp;
  logic            m_axi_rvalid;
  logic            m_axi_rready;

  modport slave (
    input  psel, penable, pwrite, paddr, pprot, pwdata, pstrb,
    output pready, prdata, pslverr,
    output m_axi_awaddr, m_axi_awprot, m_axi_awvalid,
    input  m_axi_awready,
    output m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
    input  m_axi_wready,
    input  m_axi_bresp, m_axi_bvalid,
    output m_axi_bready,
    output m_axi_araddr, m_axi_arprot, m_axi_arvalid,
    input  m_axi_arready,
    input  m_axi_rdata, m_axi_rresp, m_axi_rvalid,
    output m_axi_rready
  );

  modport master (
    output psel, penable, pwrite, paddr, pprot, pwdata, pstrb,
    input  pready, prdata, pslverr,
    input  m_axi_awaddr, m_axi_awprot, m_axi_awvalid,
    output m_axi_awready,
    input  m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
    output m_axi_wready,
    output m_axi_bresp, m_axi_bvalid,
    input  m_axi_bready,
    input  m_axi_araddr, m_axi_arprot, m_axi_arvalid,
    output m_axi_arready,
    output m_axi_rdata, m_axi_rresp, m_axi_rvalid,
    input  m_axi_rready
  );
endinterface

// File: rtl/apb2axil.sv
// APB4 completer to AXI4-Lite manager bridge, one outstanding transfer, with response timeout
// and a drain phase that retires late AXI traffic without ever dropping a pending valid.
module apb2axil #(
  parameter int unsigned AW             = 32,
  parameter int unsigned DW             = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input logic       clk_i,
  input logic       rst_i,
  apb2axil_if.slave bus
);
  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CntMax = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [2:0] {StIdle, StWrReq, StWrResp, StRdReq, StRdResp, StDone, StDrain} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d, hold_addr_q, hold_addr_d;
  logic [2:0]      prot_q, prot_d, hold_prot_q, hold_prot_d;
  logic [DW-1:0]   wdata_q, wdata_d, hold_wdata_q, hold_wdata_d;
  logic [DW/8-1:0] strb_q, strb_d, hold_strb_q, hold_strb_d;
  logic            wr_q, wr_d, hold_wr_q, hold_wr_d, hold_q, hold_d;
  logic            awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
  logic [DW-1:0]   prdata_q, prdata_d;
  logic            pslverr_q, pslverr_d;
  logic            pend_q, pend_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic aw_ok, w_ok, setup, timeout, bready, rready, resp_hs;
  logic unused_resp;

  // Only bit 1 of xRESP distinguishes error from success.
  assign unused_resp = bus.m_axi_bresp[0] ^ bus.m_axi_rresp[0];

  assign setup   = bus.psel && !bus.penable;
  assign aw_ok   = !awvalid_q || bus.m_axi_awready;
  assign w_ok    = !wvalid_q || bus.m_axi_wready;
  assign timeout = (TIMEOUT_CYCLES != 0) && (cnt_q == CntMax);
  assign bready  = (state_q == StWrReq) || (state_q == StWrResp) ||
                   (((state_q == StDone) || (state_q == StDrain)) && pend_q);
  assign rready  = (state_q == StRdReq) || (state_q == StRdResp) ||
                   (((state_q == StDone) || (state_q == StDrain)) && pend_q);
  assign resp_hs = wr_q ? (bus.m_axi_bvalid && bready) : (bus.m_axi_rvalid && rready);

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    prot_d       = prot_q;
    wdata_d      = wdata_q;
    strb_d       = strb_q;
    wr_d         = wr_q;
    hold_d       = hold_q;
    hold_addr_d  = hold_addr_q;
    hold_prot_d  = hold_prot_q;
    hold_wdata_d = hold_wdata_q;
    hold_strb_d  = hold_strb_q;
    hold_wr_d    = hold_wr_q;
    awvalid_d    = awvalid_q && !bus.m_axi_awready;
    wvalid_d     = wvalid_q && !bus.m_axi_wready;
    arvalid_d    = arvalid_q && !bus.m_axi_arready;
    prdata_d     = prdata_q;
    pslverr_d    = pslverr_q;
    pend_d       = pend_q;
    cnt_d        = cnt_q;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (hold_q || setup) begin
          hold_d    = 1'b0;
          addr_d    = hold_q ? hold_addr_q  : bus.paddr;
          prot_d    = hold_q ? hold_prot_q  : bus.pprot;
          wdata_d   = hold_q ? hold_wdata_q : bus.pwdata;
          strb_d    = hold_q ? hold_strb_q  : bus.pstrb;
          wr_d      = hold_q ? hold_wr_q    : bus.pwrite;
          awvalid_d = wr_d;
          wvalid_d  = wr_d;
          arvalid_d = !wr_d;
          state_d   = wr_d ? StWrReq : StRdReq;
        end
      end
      StWrReq, StWrResp: begin
        cnt_d = cnt_q + CW'(1);
        if (aw_ok && w_ok && bus.m_axi_bvalid) begin
          prdata_d  = '0;
          pslverr_d = bus.m_axi_bresp[1];
          state_d   = StDone;
        end else if (timeout) begin
          prdata_d  = '0;
          pslverr_d = 1'b1;
          pend_d    = 1'b1;
          state_d   = StDone;
        end else if (aw_ok && w_ok) begin
          state_d = StWrResp;
        end
      end
      StRdReq, StRdResp: begin
        cnt_d = cnt_q + CW'(1);
        if ((!arvalid_q || bus.m_axi_arready) && bus.m_axi_rvalid) begin
          prdata_d  = bus.m_axi_rdata;
          pslverr_d = bus.m_axi_rresp[1];
          state_d   = StDone;
        end else if (timeout) begin
          prdata_d  = '0;
          pslverr_d = 1'b1;
          pend_d    = 1'b1;
          state_d   = StDone;
        end else if (!arvalid_q || bus.m_axi_arready) begin
          state_d = StRdResp;
        end
      end
      StDone: begin
        cnt_d = '0;
        if (pend_q && !resp_hs) begin
          state_d = StDrain;
        end else begin
          pend_d  = 1'b0;
          state_d = StIdle;
        end
      end
      StDrain: begin
        // Request regs still drive pending AXI valids, so a new setup goes to the hold regs.
        if (setup) begin
          hold_d       = 1'b1;
          hold_addr_d  = bus.paddr;
          hold_prot_d  = bus.pprot;
          hold_wdata_d = bus.pwdata;
          hold_strb_d  = bus.pstrb;
          hold_wr_d    = bus.pwrite;
        end
        if (resp_hs) begin
          pend_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      prot_q       <= '0;
      wdata_q      <= '0;
      strb_q       <= '0;
      wr_q         <= 1'b0;
      hold_q       <= 1'b0;
      hold_addr_q  <= '0;
      hold_prot_q  <= '0;
      hold_wdata_q <= '0;
      hold_strb_q  <= '0;
      hold_wr_q    <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      prdata_q     <= '0;
      pslverr_q    <= 1'b0;
      pend_q       <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      prot_q       <= prot_d;
      wdata_q      <= wdata_d;
      strb_q       <= strb_d;
      wr_q         <= wr_d;
      hold_q       <= hold_d;
      hold_addr_q  <= hold_addr_d;
      hold_prot_q  <= hold_prot_d;
      hold_wdata_q <= hold_wdata_d;
      hold_strb_q  <= hold_strb_d;
      hold_wr_q    <= hold_wr_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      arvalid_q    <= arvalid_d;
      prdata_q     <= prdata_d;
      pslverr_q    <= pslverr_d;
      pend_q       <= pend_d;
      cnt_q        <= cnt_d;
    end
  end

  assign bus.pready        = (state_q == StDone);
  assign bus.prdata        = (state_q == StDone) ? prdata_q : '0;
  assign bus.pslverr       = (state_q == StDone) && pslverr_q;
  assign bus.m_axi_awaddr  = addr_q;
  assign bus.m_axi_awprot  = prot_q;
  assign bus.m_axi_awvalid = awvalid_q;
  assign bus.m_axi_wdata   = wdata_q;
  assign bus.m_axi_wstrb   = strb_q;
  assign bus.m_axi_wvalid  = wvalid_q;
  assign bus.m_axi_bready  = bready;
  assign bus.m_axi_araddr  = addr_q;
  assign bus.m_axi_arprot  = prot_q;
  assign bus.m_axi_arvalid = arvalid_q;
  assign bus.m_axi_rready  = rready;
endmodule
